if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline, directly upstream of the ID-stage controller.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched instruction and PC+4 into IF/ID and exposes the opcode field to the controller.
- Honours hazard-unit stalls (PC_Write, IFID_Write), ID-stage branch redirects, and the controller's IF_Flush.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
PC_W, 32, width of PC and addresses
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the stall and flush counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
PC_Write  in  1  1 = PC may update; 0 = hold PC (load-use stall)
IFID_Write  in  1  1 = IF/ID may update; 0 = hold IF/ID
IF_Flush  in  1  from controller; asserted while a beq is in ID
branch_taken  in  1  ID-stage compare result for the beq in ID
branch_target  in  PC_W  ID-stage computed branch target
imem_instr  in  32  instruction at imem_addr (combinational read)
imem_addr  out  PC_W  current PC
if_id_instr  out  32  IF/ID instruction
if_id_pc4  out  PC_W  IF/ID PC+4
if_id_valid  out  1  IF/ID holds a real instruction
op  out  6  if_id_instr[31:26], to controller
stall_cnt  out  CNT_W  cycles with IFID_Write=0 while RUN
flush_cnt  out  CNT_W  number of flushes applied

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, if_id_instr=32'h0 (nop), if_id_pc4=0, if_id_valid=0, stall_cnt=0, flush_cnt=0, state=BOOT.
- FSM states:
  - BOOT: one cycle after reset release. PC and IF/ID hold their reset values; counters do not count; go to RUN.
  - RUN: normal operation; stays in RUN until reset.
- redirect = IF_Flush & branch_taken.
- next_pc = redirect ? {branch_target[PC_W-1:2],2'b00} : pc+4. Addition wraps modulo 2^PC_W; no overflow flag.
- PC update (RUN): pc<=next_pc only when PC_Write=1. PC_Write=0 holds pc even if redirect=1; the stall dominates, and the branch is re-evaluated when it releases.
- IF/ID update (RUN), in priority order:
  1. IFID_Write=0: hold all IF/ID fields; stall_cnt+1, saturating at all-ones.
  2. redirect=1: if_id_instr<=0, if_id_valid<=0, if_id_pc4<=0; flush_cnt+1, saturating.
  3. Otherwise: if_id_instr<=imem_instr, if_id_pc4<=pc+4, if_id_valid<=1.
- IF_Flush=1 with branch_taken=0 (beq not taken): no flush, sequential fetch continues.
- Latency: an instruction at address A appears on if_id_instr/op one cycle after pc==A with no stall. A taken branch costs one bubble.
- op is combinational from the IF/ID register, with no extra delay.
- imem_addr=pc at all times, including BOOT.
- Reset asserted mid-stall or mid-flush returns all state to reset values immediately, with no dependence on the clock.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR=32'h0, PC_INC=4
  - OP_MSB=31, OP_LSB=26
  - opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100
  - state encoding BOOT=1'b0, RUN=1'b1
- One natural sub-module: pc_reg. It holds the PC register with the enable, the async reset to RESET_PC, and the next_pc mux. IF/ID, the FSM and the counters stay in if_id_stage.

Test Plan:
- Reset/boot: hold rst_n=0, then release. Required: imem_addr=0 for 2 cycles (reset + BOOT), if_id_valid=0, then imem_addr steps 0x4, 0x8 and the instruction fetched at 0x0 appears on if_id_instr with if_id_pc4=0x4.
- Sequential fetch: imem returns 0x8C080004 (lw) at 0x0. Required: op=6'b100011 one cycle after that fetch cycle, if_id_valid=1.
- Load-use stall: PC_Write=0, IFID_Write=0 for 1 cycle at pc=0x8. Required: pc stays 0x8 and IF/ID unchanged for that cycle; stall_cnt=1; fetch resumes at 0xC.
- Taken beq: IF_Flush=1, branch_taken=1, branch_target=0x40 at pc=0x10. Required: next imem_addr=0x40, if_id_instr=0, if_id_valid=0, flush_cnt=1; the instruction at 0x40 appears in IF/ID one cycle later.
- Not-taken beq, then stall vs. branch:
  - IF_Flush=1, branch_taken=0. Required: pc+4 fetch, no flush, flush_cnt unchanged.
  - IF_Flush=1, branch_taken=1, PC_Write=0, IFID_Write=0. Required: pc and IF/ID held, flush_cnt unchanged.
- Async reset mid-run plus saturation:
  - Drop rst_n between clock edges. Required: outputs reach reset values before the next edge.
  - With CNT_W=2, apply 5 stall cycles. Required: stall_cnt=3.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants, opcodes and fetch FSM encoding
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_INC    = 4;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage : mips_pkg

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with write enable and branch-redirect next-PC mux
module pc_reg
  import mips_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_en,
  input  logic            redirect,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  // Branch targets are always word aligned; the low two bits are forced to zero.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target[1:0];

  // Next PC: sequential +4 (wrapping) or the aligned branch target, gated by the enable.
  always_comb begin
    pc_plus4 = pc_q + PC_W'(PC_INC);
    pc_d     = pc_q;
    if (pc_en) begin
      pc_d = redirect ? {branch_target[PC_W-1:2], 2'b00} : pc_plus4;
    end
  end

  // PC register with asynchronous reset to the boot address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : pc_reg

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - instruction fetch stage and IF/ID pipeline register with stall/flush counters
module if_id_stage
  import mips_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PC_Write,
  input  logic             IFID_Write,
  input  logic             IF_Flush,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic [31:0]      imem_instr,
  output logic [PC_W-1:0]  imem_addr,
  output logic [31:0]      if_id_instr,
  output logic [PC_W-1:0]  if_id_pc4,
  output logic             if_id_valid,
  output logic [5:0]       op,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fetch_state_e     state_d, state_q;
  logic [31:0]      if_id_instr_d, if_id_instr_q;
  logic [PC_W-1:0]  if_id_pc4_d, if_id_pc4_q;
  logic             if_id_valid_d, if_id_valid_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  logic            run;
  logic            redirect;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;

  assign run      = (state_q == RUN);
  assign redirect = IF_Flush & branch_taken;

  // A stalled PC ignores a pending redirect; the branch is re-evaluated after the stall.
  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_en         (run & PC_Write),
    .redirect      (redirect),
    .branch_target (branch_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4)
  );

  // BOOT lasts exactly one cycle after reset release, then fetch runs until the next reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // IF/ID update: stall beats flush beats normal load; counters saturate at all-ones.
  always_comb begin
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    if (run) begin
      if (!IFID_Write) begin
        if (stall_cnt_q != {CNT_W{1'b1}}) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end else if (redirect) begin
        if_id_instr_d = NOP_INSTR;
        if_id_pc4_d   = '0;
        if_id_valid_d = 1'b0;
        if (flush_cnt_q != {CNT_W{1'b1}}) begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end else begin
        if_id_instr_d = imem_instr;
        if_id_pc4_d   = pc_plus4;
        if_id_valid_d = 1'b1;
      end
    end
  end

  // Pipeline register, FSM state and counters, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc4_q   <= '0;
      if_id_valid_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign imem_addr   = pc;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign op          = if_id_instr_q[OP_MSB:OP_LSB];
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule : if_id_stage

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed self-checking bench for if_id_stage
module tb_if_id_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        PC_Write;
  logic        IFID_Write;
  logic        IF_Flush;
  logic        branch_taken;
  logic [31:0] branch_target;

  logic [31:0] imem_instr, imem_addr, if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  op;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] imem_instr_s, imem_addr_s, if_id_instr_s, if_id_pc4_s;
  logic        if_id_valid_s;
  logic [5:0]  op_s;
  logic [1:0]  stall_cnt_s, flush_cnt_s;

  int compared;
  int mismatched;

  // Instruction memory: lw at 0x0, elsewhere a tag word carrying its own address.
  function automatic logic [31:0] imem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C08_0004;
    return {8'hE0, a[23:0]};
  endfunction

  assign imem_instr   = imem_f(imem_addr);
  assign imem_instr_s = imem_f(imem_addr_s);

  if_id_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PC_Write      (PC_Write),
    .IFID_Write    (IFID_Write),
    .IF_Flush      (IF_Flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_instr    (imem_instr),
    .imem_addr     (imem_addr),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .op            (op),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  if_id_stage #(.CNT_W(2)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .PC_Write      (PC_Write),
    .IFID_Write    (IFID_Write),
    .IF_Flush      (IF_Flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_instr    (imem_instr_s),
    .imem_addr     (imem_addr_s),
    .if_id_instr   (if_id_instr_s),
    .if_id_pc4     (if_id_pc4_s),
    .if_id_valid   (if_id_valid_s),
    .op            (op_s),
    .stall_cnt     (stall_cnt_s),
    .flush_cnt     (flush_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic [31:0] pc4,
                            input logic valid);
    check({tag, "_pc"},    imem_addr, pc);
    check({tag, "_instr"}, if_id_instr, instr);
    check({tag, "_pc4"},   if_id_pc4, pc4);
    check({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, valid});
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    PC_Write      = 1'b1;
    IFID_Write    = 1'b1;
    IF_Flush      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;

    step();
    step();
    check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    check("reset_stall", {16'b0, stall_cnt}, 32'h0);
    check("reset_flush", {16'b0, flush_cnt}, 32'h0);
    check("reset_op", {26'b0, op}, 32'h0);

    rst_n = 1'b1;
    step();
    check_ifid("boot", 32'h0, 32'h0, 32'h0, 1'b0);

    step();
    check_ifid("fetch0", 32'h4, 32'h8C08_0004, 32'h4, 1'b1);
    check("fetch0_op", {26'b0, op}, {26'b0, OP_LW});

    step();
    check_ifid("fetch4", 32'h8, 32'hE000_0004, 32'h8, 1'b1);

    PC_Write   = 1'b0;
    IFID_Write = 1'b0;
    step();
    check_ifid("stall", 32'h8, 32'hE000_0004, 32'h8, 1'b1);
    check("stall_cnt1", {16'b0, stall_cnt}, 32'h1);

    PC_Write   = 1'b1;
    IFID_Write = 1'b1;
    step();
    check_ifid("resume8", 32'hC, 32'hE000_0008, 32'hC, 1'b1);
    step();
    check_ifid("fetchC", 32'h10, 32'hE000_000C, 32'h10, 1'b1);

    IF_Flush      = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h43;
    step();
    check_ifid("taken", 32'h40, 32'h0, 32'h0, 1'b0);
    check("taken_flush", {16'b0, flush_cnt}, 32'h1);
    check("taken_op", {26'b0, op}, 32'h0);

    IF_Flush     = 1'b0;
    branch_taken = 1'b0;
    step();
    check_ifid("target", 32'h44, 32'hE000_0040, 32'h44, 1'b1);

    IF_Flush = 1'b1;
    step();
    check_ifid("not_taken", 32'h48, 32'hE000_0044, 32'h48, 1'b1);
    check("not_taken_flush", {16'b0, flush_cnt}, 32'h1);

    branch_taken  = 1'b1;
    branch_target = 32'h80;
    PC_Write      = 1'b0;
    IFID_Write    = 1'b0;
    step();
    check_ifid("stall_br", 32'h48, 32'hE000_0044, 32'h48, 1'b1);
    check("stall_br_flush", {16'b0, flush_cnt}, 32'h1);
    check("stall_br_stall", {16'b0, stall_cnt}, 32'h2);

    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IF_Flush     = 1'b0;
    branch_taken = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_ifid("async", 32'h0, 32'h0, 32'h0, 1'b0);
    check("async_stall", {16'b0, stall_cnt}, 32'h0);
    check("async_flush", {16'b0, flush_cnt}, 32'h0);

    step();
    rst_n = 1'b1;
    step();
    check("reboot_pc", imem_addr, 32'h0);

    PC_Write   = 1'b0;
    IFID_Write = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("sat_stall", {30'b0, stall_cnt_s}, 32'h3);
    check("wide_stall", {16'b0, stall_cnt}, 32'h5);
    check("sat_pc", imem_addr_s, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_if_id_stage
